// File: rtl/dot_matrix_frame_arbiter.sv
// dot_matrix_frame_arbiter: shares the 8x8 R/G frame bus between a status client (A) and a pre-empting alarm client (B)
module dot_matrix_frame_arbiter #(
    parameter int HOLD_TICKS  = 50,
    parameter int BLINK_TICKS = 25,
    parameter int CNT_W       = 8
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [63:0] a_R,
    input  logic [63:0] a_G,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [63:0] b_R,
    input  logic [63:0] b_G,
    input  logic        b_blink,
    input  logic        b_release,
    output logic [63:0] dot_matrix_R,
    output logic [63:0] dot_matrix_G,
    output logic [1:0]  owner,
    output logic        frame_update
);
    typedef enum logic [1:0] {IDLE, SHOW_A, SHOW_B} state_t;
    state_t state, state_nxt;
    logic a_xfer, b_xfer, exit_b, wrap;
    logic sh_valid, bq_blink, bq_blink_nxt, hidden, hidden_nxt, rel_pend;
    logic [63:0] sh_R, sh_G, bq_R, bq_G, sh_R_nxt, sh_G_nxt, bq_R_nxt, bq_G_nxt, R_nxt, G_nxt;
    logic [CNT_W-1:0] hold_cnt, blink_cnt, blink_cnt_nxt;
    logic [1:0] owner_nxt;
    assign a_xfer = a_valid & a_ready;
    assign b_xfer = b_valid & b_ready;
    // a fresh B frame always outranks a pending release
    assign exit_b = state == SHOW_B && hold_cnt == '0 && rel_pend && !b_xfer;
    assign wrap   = blink_cnt == CNT_W'(BLINK_TICKS - 1);
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state        <= IDLE;
            sh_valid     <= 1'b0;
            sh_R         <= '0;
            sh_G         <= '0;
            bq_R         <= '0;
            bq_G         <= '0;
            bq_blink     <= 1'b0;
            hidden       <= 1'b0;
            blink_cnt    <= '0;
            hold_cnt     <= '0;
            rel_pend     <= 1'b0;
            dot_matrix_R <= '0;
            dot_matrix_G <= '0;
            owner        <= 2'b00;
            frame_update <= 1'b0;
        end else begin
            state        <= state_nxt;
            sh_valid     <= sh_valid | a_xfer;
            sh_R         <= sh_R_nxt;
            sh_G         <= sh_G_nxt;
            bq_R         <= bq_R_nxt;
            bq_G         <= bq_G_nxt;
            bq_blink     <= bq_blink_nxt;
            hidden       <= hidden_nxt;
            blink_cnt    <= blink_cnt_nxt;
            hold_cnt     <= b_xfer ? CNT_W'(HOLD_TICKS) :
                            (state == SHOW_B && hold_cnt != '0) ? hold_cnt - 1'b1 : hold_cnt;
            rel_pend     <= (b_xfer || exit_b) ? 1'b0 : (state == SHOW_B && b_release) ? 1'b1 : rel_pend;
            dot_matrix_R <= R_nxt;
            dot_matrix_G <= G_nxt;
            owner        <= owner_nxt;
            frame_update <= R_nxt != dot_matrix_R || G_nxt != dot_matrix_G || owner_nxt != owner;
        end
    end
    always_comb begin
        state_nxt = state;
        if (b_xfer)
            state_nxt = SHOW_B;
        else if (state == IDLE && a_xfer)
            state_nxt = SHOW_A;
        else if (exit_b)
            state_nxt = sh_valid ? SHOW_A : IDLE;
    end
    // outputs are computed from the next state so a frame is visible the cycle after its transfer
    always_comb begin
        a_ready       = !rst && state != SHOW_B;
        b_ready       = !rst;
        sh_R_nxt      = a_xfer ? a_R : sh_R;
        sh_G_nxt      = a_xfer ? a_G : sh_G;
        bq_R_nxt      = b_xfer ? b_R : bq_R;
        bq_G_nxt      = b_xfer ? b_G : bq_G;
        bq_blink_nxt  = b_xfer ? b_blink : bq_blink;
        blink_cnt_nxt = (b_xfer || !bq_blink || state != SHOW_B || wrap) ? '0 : blink_cnt + 1'b1;
        hidden_nxt    = (b_xfer || !bq_blink || state != SHOW_B) ? 1'b0 : hidden ^ wrap;
        R_nxt         = state_nxt == SHOW_B ? (hidden_nxt ? '0 : bq_R_nxt) : state_nxt == SHOW_A ? sh_R_nxt : '0;
        G_nxt         = state_nxt == SHOW_B ? (hidden_nxt ? '0 : bq_G_nxt) : state_nxt == SHOW_A ? sh_G_nxt : '0;
        owner_nxt     = state_nxt == SHOW_B ? 2'b10 : state_nxt == SHOW_A ? 2'b01 : 2'b00;
    end
endmodule
